// File: rtl/clock_face_renderer_if.sv
// Pixel-source bus between the VGA driver and the clock face renderer.
// The driver side supplies the scan counters and time; the renderer returns colour.
interface clock_face_renderer_if;
   logic [9:0]  Hcnt;
   logic [9:0]  Vcnt;
   logic [23:0] time_bcd;
   logic        time_valid;
   logic [3:0]  red_color;
   logic [3:0]  green_color;
   logic [3:0]  blue_color;
   logic        drive_enable;

   modport master (
      output Hcnt, Vcnt, time_bcd, time_valid,
      input  red_color, green_color, blue_color, drive_enable
   );

   modport slave (
      input  Hcnt, Vcnt, time_bcd, time_valid,
      output red_color, green_color, blue_color, drive_enable
   );
endinterface

// File: rtl/clock_face_renderer.sv
// Renders HH:MM:SS as seven-segment digits with blinking colons from the VGA scan counters.
// Two-stage pipeline: stage 1 locates the pixel in the digit row, stage 2 picks its colour.
module clock_face_renderer #(
   parameter logic [9:0]  H_DISP_ON    = 10'd144,
   parameter logic [9:0]  V_DISP_ON    = 10'd35,
   parameter logic [9:0]  V_DISP_LINES = 10'd480,
   parameter int          X0           = 64,
   parameter int          Y0           = 176,
   parameter int          DIGIT_W      = 64,
   parameter int          DIGIT_H      = 128,
   parameter int          COLON_W      = 32,
   parameter int          SEG_T        = 12,
   parameter int          BLINK_FRAMES = 30,
   parameter logic [11:0] FG_RGB       = 12'hFFF,
   parameter logic [11:0] BG_RGB       = 12'h004
) (
   input  logic                        clock_100mhz,
   input  logic                        reset_n,
   clock_face_renderer_if.slave        bus
);

   localparam logic [9:0] X0_P   = 10'(X0);
   localparam logic [9:0] Y0_P   = 10'(Y0);
   localparam logic [9:0] ROW_XE = 10'(X0 + 6 * DIGIT_W + 2 * COLON_W);
   localparam logic [9:0] ROW_YE = 10'(Y0 + DIGIT_H);
   localparam logic [9:0] V_END  = 10'(V_DISP_ON + V_DISP_LINES);
   localparam logic [9:0] B1     = 10'(DIGIT_W);
   localparam logic [9:0] B2     = 10'(2 * DIGIT_W);
   localparam logic [9:0] B3     = 10'(2 * DIGIT_W + COLON_W);
   localparam logic [9:0] B4     = 10'(3 * DIGIT_W + COLON_W);
   localparam logic [9:0] B5     = 10'(4 * DIGIT_W + COLON_W);
   localparam logic [9:0] B6     = 10'(4 * DIGIT_W + 2 * COLON_W);
   localparam logic [9:0] B7     = 10'(5 * DIGIT_W + 2 * COLON_W);

   localparam logic [7:0] SEG_TK  = 8'(SEG_T);
   localparam logic [7:0] SEG_R   = 8'(DIGIT_W - SEG_T);
   localparam logic [7:0] SEG_MID = 8'(DIGIT_H / 2);
   localparam logic [7:0] SEG_BOT = 8'(DIGIT_H - SEG_T);
   localparam logic [7:0] SEG_GLO = 8'(DIGIT_H / 2 - SEG_T / 2);
   localparam logic [7:0] SEG_GHI = 8'(DIGIT_H / 2 + SEG_T / 2);
   localparam logic [7:0] DOT_ULO = 8'(COLON_W / 2 - SEG_T / 2);
   localparam logic [7:0] DOT_UHI = 8'(COLON_W / 2 - SEG_T / 2 + SEG_T);
   localparam logic [7:0] FRAME_LAST = 8'(BLINK_FRAMES - 1);

   logic [23:0] pending_q, pending_d, shadow_q, shadow_d;
   logic [9:0]  vcnt_prev_q, vcnt_prev_d;
   logic [7:0]  frame_cnt_q, frame_cnt_d;
   logic        phase_q, phase_d;
   logic        v_active_q, v_active_d;
   logic        in_region_q, in_region_d;
   logic [2:0]  cell_q, cell_d;
   logic [7:0]  u_q, u_d, v_q, v_d;
   logic [11:0] color_q, color_d;
   logic        drive_enable_q, drive_enable_d;

   logic        frame_start;
   logic        h_on;
   logic [9:0]  x_pix, y_pix, rx;
   logic [3:0]  digit;
   logic [6:0]  segs;
   logic        seg_hit, dot_hit, lit;

   // Segment bits are {a,b,c,d,e,f,g}; non-decimal codes stay dark.
   function automatic logic [6:0] seg_map(input logic [3:0] d);
      case (d)
         4'd0:    seg_map = 7'b1111110;
         4'd1:    seg_map = 7'b0110000;
         4'd2:    seg_map = 7'b1101101;
         4'd3:    seg_map = 7'b1111001;
         4'd4:    seg_map = 7'b0110011;
         4'd5:    seg_map = 7'b1011011;
         4'd6:    seg_map = 7'b1011111;
         4'd7:    seg_map = 7'b1110000;
         4'd8:    seg_map = 7'b1111111;
         4'd9:    seg_map = 7'b1111011;
         default: seg_map = 7'b0000000;
      endcase
   endfunction

   // Time is staged in pending and only promoted to shadow at frame start to avoid tearing.
   always_comb begin
      frame_start = (bus.Vcnt == 10'd0) && (vcnt_prev_q != 10'd0);
      vcnt_prev_d = bus.Vcnt;
      pending_d   = bus.time_valid ? bus.time_bcd : pending_q;
      shadow_d    = shadow_q;
      frame_cnt_d = frame_cnt_q;
      phase_d     = phase_q;
      if (frame_start) begin
         shadow_d = bus.time_valid ? bus.time_bcd : pending_q;
         if (frame_cnt_q == FRAME_LAST) begin
            frame_cnt_d = 8'd0;
            phase_d     = ~phase_q;
         end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
         end
      end
   end

   // Stage 1: bounds are compared before subtracting so offsets never wrap.
   always_comb begin
      v_active_d  = (bus.Vcnt >= V_DISP_ON) && (bus.Vcnt < V_END);
      h_on        = bus.Hcnt >= H_DISP_ON;
      x_pix       = h_on ? bus.Hcnt - H_DISP_ON : 10'd0;
      y_pix       = v_active_d ? bus.Vcnt - V_DISP_ON : 10'd0;
      in_region_d = h_on && v_active_d && (x_pix >= X0_P) && (x_pix < ROW_XE)
                    && (y_pix >= Y0_P) && (y_pix < ROW_YE);
      rx          = in_region_d ? x_pix - X0_P : 10'd0;
      v_d         = in_region_d ? 8'(y_pix - Y0_P) : 8'd0;
      cell_d      = 3'd0;
      u_d         = 8'(rx);
      if (rx < B1) begin
         cell_d = 3'd0; u_d = 8'(rx);
      end else if (rx < B2) begin
         cell_d = 3'd1; u_d = 8'(rx - B1);
      end else if (rx < B3) begin
         cell_d = 3'd6; u_d = 8'(rx - B2);
      end else if (rx < B4) begin
         cell_d = 3'd2; u_d = 8'(rx - B3);
      end else if (rx < B5) begin
         cell_d = 3'd3; u_d = 8'(rx - B4);
      end else if (rx < B6) begin
         cell_d = 3'd7; u_d = 8'(rx - B5);
      end else if (rx < B7) begin
         cell_d = 3'd4; u_d = 8'(rx - B6);
      end else begin
         cell_d = 3'd5; u_d = 8'(rx - B7);
      end
   end

   // Stage 2: cells 6 and 7 are the colons, 0..5 the digits left to right.
   always_comb begin
      case (cell_q)
         3'd0:    digit = shadow_q[23:20];
         3'd1:    digit = shadow_q[19:16];
         3'd2:    digit = shadow_q[15:12];
         3'd3:    digit = shadow_q[11:8];
         3'd4:    digit = shadow_q[7:4];
         3'd5:    digit = shadow_q[3:0];
         default: digit = 4'hF;
      endcase
      segs    = seg_map(digit);
      seg_hit = (segs[6] && v_q < SEG_TK)
             || (segs[5] && u_q >= SEG_R && v_q < SEG_MID)
             || (segs[4] && u_q >= SEG_R && v_q >= SEG_MID)
             || (segs[3] && v_q >= SEG_BOT)
             || (segs[2] && u_q < SEG_TK && v_q >= SEG_MID)
             || (segs[1] && u_q < SEG_TK && v_q < SEG_MID)
             || (segs[0] && v_q >= SEG_GLO && v_q < SEG_GHI);
      dot_hit = !phase_q && (u_q >= DOT_ULO) && (u_q < DOT_UHI)
             && (((v_q >= 8'd32) && (v_q < 8'd44)) || ((v_q >= 8'd84) && (v_q < 8'd96)));
      lit     = in_region_q && (cell_q[2:1] == 2'b11 ? dot_hit : seg_hit);
      color_d = !v_active_q ? 12'h000 : (lit ? FG_RGB : BG_RGB);
      drive_enable_d = v_active_q;
   end

   always_ff @(posedge clock_100mhz) begin
      if (!reset_n) begin
         pending_q      <= '0;
         shadow_q       <= '0;
         vcnt_prev_q    <= '0;
         frame_cnt_q    <= '0;
         phase_q        <= 1'b0;
         v_active_q     <= 1'b0;
         in_region_q    <= 1'b0;
         cell_q         <= '0;
         u_q            <= '0;
         v_q            <= '0;
         color_q        <= '0;
         drive_enable_q <= 1'b0;
      end else begin
         pending_q      <= pending_d;
         shadow_q       <= shadow_d;
         vcnt_prev_q    <= vcnt_prev_d;
         frame_cnt_q    <= frame_cnt_d;
         phase_q        <= phase_d;
         v_active_q     <= v_active_d;
         in_region_q    <= in_region_d;
         cell_q         <= cell_d;
         u_q            <= u_d;
         v_q            <= v_d;
         color_q        <= color_d;
         drive_enable_q <= drive_enable_d;
      end
   end

   assign bus.red_color    = color_q[11:8];
   assign bus.green_color  = color_q[7:4];
   assign bus.blue_color   = color_q[3:0];
   assign bus.drive_enable = drive_enable_q;

endmodule

// File: tb/tb_clock_face_renderer.sv
// Directed bench for clock_face_renderer: hand-computed pixels for digits, colons, blink and reset.
module tb_clock_face_renderer;

   localparam logic [12:0] PIX_FG  = 13'h1FFF;
   localparam logic [12:0] PIX_BG  = 13'h1004;
   localparam logic [12:0] PIX_OFF = 13'h0000;

   logic clk;
   logic reset_n;
   int   checks;
   int   errors;

   clock_face_renderer_if bus();

   clock_face_renderer dut (
      .clock_100mhz (clk),
      .reset_n      (reset_n),
      .bus          (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [12:0] got, input logic [12:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got de/rgb=%h required %h", tag, got, exp);
      end
   endtask

   function automatic logic [12:0] observed();
      return {bus.drive_enable, bus.red_color, bus.green_color, bus.blue_color};
   endfunction

   // Hold a pixel long enough for both pipeline stages, then sample mid-cycle.
   task automatic probe(input string tag, input logic [9:0] h, input logic [9:0] v,
                        input logic [12:0] exp);
      @(negedge clk);
      bus.Hcnt = h;
      bus.Vcnt = v;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check_output(tag, observed(), exp);
   endtask

   task automatic load_time(input logic [23:0] bcd);
      @(negedge clk);
      bus.Vcnt       = 10'd100;
      bus.time_bcd   = bcd;
      bus.time_valid = 1'b1;
      @(negedge clk);
      bus.time_valid = 1'b0;
   endtask

   task automatic frame_pulse();
      @(negedge clk);
      bus.Vcnt = 10'd524;
      @(negedge clk);
      bus.Vcnt = 10'd0;
      @(negedge clk);
      bus.Vcnt = 10'd1;
   endtask

   initial begin
      checks         = 0;
      errors         = 0;
      reset_n        = 1'b0;
      bus.Hcnt       = 10'd238;
      bus.Vcnt       = 10'd216;
      bus.time_bcd   = 24'h0;
      bus.time_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check_output("reset", observed(), PIX_OFF);
      reset_n = 1'b1;

      probe("vblank_10", 10'd0, 10'd10, PIX_OFF);
      probe("v_first_inactive", 10'd100, 10'd34, PIX_OFF);
      probe("v_first_active", 10'd100, 10'd35, PIX_BG);
      probe("v_last_active", 10'd100, 10'd514, PIX_BG);
      probe("v_end_inactive", 10'd100, 10'd515, PIX_OFF);
      probe("hblank_bg", 10'd100, 10'd220, PIX_BG);
      probe("right_of_row_bg", 10'd700, 10'd220, PIX_BG);

      load_time(24'h123456);
      probe("pending_hidden_g", 10'd300, 10'd275, PIX_BG);
      probe("pending_zero_a", 10'd238, 10'd216, PIX_FG);
      frame_pulse();
      probe("swap_d1_g", 10'd300, 10'd275, PIX_FG);
      probe("swap_d0_no_a", 10'd238, 10'd216, PIX_BG);
      probe("swap_d0_b", 10'd265, 10'd220, PIX_FG);

      load_time(24'hA23456);
      frame_pulse();
      probe("blank_d0_b", 10'd265, 10'd220, PIX_BG);
      probe("blank_d0_d", 10'd238, 10'd331, PIX_BG);
      probe("blank_d0_f", 10'd210, 10'd220, PIX_BG);
      probe("d1_still_g", 10'd300, 10'd275, PIX_FG);

      probe("colon_frame2", 10'd350, 10'd248, PIX_FG);
      repeat (27) frame_pulse();
      probe("colon_frame29", 10'd350, 10'd248, PIX_FG);
      frame_pulse();
      probe("colon_frame30", 10'd350, 10'd248, PIX_BG);
      repeat (29) frame_pulse();
      probe("colon_frame59", 10'd350, 10'd248, PIX_BG);
      frame_pulse();
      probe("colon_frame60", 10'd350, 10'd248, PIX_FG);
      probe("colon1_low_dot", 10'd510, 10'd300, PIX_FG);

      @(negedge clk);
      bus.Vcnt = 10'd524;
      @(negedge clk);
      bus.Vcnt       = 10'd0;
      bus.time_bcd   = 24'h000001;
      bus.time_valid = 1'b1;
      @(negedge clk);
      bus.time_valid = 1'b0;
      bus.Vcnt       = 10'd1;
      probe("coincident_d5_b", 10'd650, 10'd220, PIX_FG);
      probe("coincident_d5_no_e", 10'd597, 10'd284, PIX_BG);
      probe("coincident_d0_a", 10'd238, 10'd216, PIX_FG);

      probe("lat_hold", 10'd238, 10'd216, PIX_FG);
      @(negedge clk);
      bus.Hcnt = 10'd100;
      bus.Vcnt = 10'd220;
      @(posedge clk);
      @(negedge clk);
      check_output("latency_1cyc", observed(), PIX_FG);
      @(posedge clk);
      @(negedge clk);
      check_output("latency_2cyc", observed(), PIX_BG);

      probe("pre_reset_d5_no_e", 10'd597, 10'd284, PIX_BG);
      @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_output("midline_reset", observed(), PIX_OFF);
      reset_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_output("release_1cyc", observed(), PIX_OFF);
      @(posedge clk);
      @(negedge clk);
      check_output("release_2cyc_zero_e", observed(), PIX_FG);
      load_time(24'h000001);
      probe("reset_shows_zero_b", 10'd650, 10'd220, PIX_FG);
      probe("reset_no_swap_e", 10'd597, 10'd284, PIX_FG);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
